// File: rtl/wbq_pkg.sv
// wbq_pkg: shared types and constants for the register file writeback queue.
package wbq_pkg;
    typedef logic [4:0] reg_idx_t;
    typedef logic [31:0] word_t;
    typedef struct packed {
        reg_idx_t rd;
        word_t data;
    } wbq_entry_t;
    localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match: youngest-first forwarding search over queue entries plus an optional bypass candidate.
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  wbq_entry_t [DEPTH-1:0] ents,
    input  logic [DEPTH-1:0]       valid,
    input  logic [PW-1:0]          head,
    input  logic                   byp_valid,
    input  wbq_entry_t             byp,
    input  reg_idx_t               rs,
    output logic                   hit,
    output word_t                  data
);
    logic [PW-1:0] idx;
    // Walk oldest to youngest so the last match wins; bypass is younger than any stored entry.
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && ents[idx].rd == rs) begin
                hit = 1'b1;
                data = ents[idx].data;
            end
        end
        if (byp_valid && byp.rd == rs) begin
            hit = 1'b1;
            data = byp.data;
        end
        if (rs == REG_ZERO) begin
            hit = 1'b0;
            data = '0;
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of pending register writes draining one per cycle, with operand forwarding.
// Define WBQ_ENQ_BYPASS_EN to let forwarding also see the result being accepted this cycle.
module regfile_wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  reg_idx_t      enq_rd,
    input  word_t         enq_data,
    input  logic          wb_stall,
    output logic          wb_load,
    output reg_idx_t      wb_rd,
    output word_t         wb_in,
    input  reg_idx_t      rs1,
    input  reg_idx_t      rs2,
    output logic          fwd_a_hit,
    output logic          fwd_b_hit,
    output word_t         fwd_a_data,
    output word_t         fwd_b_data,
    output logic [CW-1:0] occupancy
);
    wbq_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [DEPTH-1:0] valid;
    logic acc, byp_valid;
    wbq_entry_t byp;

    assign wb_load = (count != '0) && !wb_stall;
    assign enq_ready = (count < CW'(DEPTH)) || wb_load;
    assign acc = enq_valid && enq_ready && (enq_rd != REG_ZERO);
    // Storage is uninitialised, so the head is masked whenever the queue is empty.
    assign wb_rd = (count != '0) ? mem[head].rd : REG_ZERO;
    assign wb_in = (count != '0) ? mem[head].data : '0;
    assign occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (acc) tail <= tail + 1'b1;
            if (wb_load) head <= head + 1'b1;
            count <= count + CW'(acc) - CW'(wb_load);
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem[tail] <= '{rd: enq_rd, data: enq_data};
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        assign valid[i] = {1'b0, PW'(i) - head} < count;
    end

`ifdef WBQ_ENQ_BYPASS_EN
    assign byp_valid = acc;
    assign byp = '{rd: enq_rd, data: enq_data};
`else
    assign byp_valid = 1'b0;
    assign byp = '0;
`endif

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .ents(mem), .valid(valid), .head(head), .byp_valid(byp_valid), .byp(byp),
        .rs(rs1), .hit(fwd_a_hit), .data(fwd_a_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .ents(mem), .valid(valid), .head(head), .byp_valid(byp_valid), .byp(byp),
        .rs(rs2), .hit(fwd_b_hit), .data(fwd_b_data)
    );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed stimulus with a scoreboard of expected register file writes.
module tb_regfile_wb_queue;
    logic clk = 1'b0, rst_n = 1'b0;
    logic enq_valid = 1'b0, enq_ready, wb_stall = 1'b0, wb_load;
    logic [4:0] enq_rd = '0, wb_rd, rs1 = '0, rs2 = '0;
    logic [31:0] enq_data = '0, wb_in, fwd_a_data, fwd_b_data;
    logic fwd_a_hit, fwd_b_hit;
    logic [2:0] occupancy;
    int checks = 0, failures = 0;
    logic [36:0] sb[$];

    regfile_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rd(enq_rd), .enq_data(enq_data), .wb_stall(wb_stall), .wb_load(wb_load),
        .wb_rd(wb_rd), .wb_in(wb_in), .rs1(rs1), .rs2(rs2), .fwd_a_hit(fwd_a_hit),
        .fwd_b_hit(fwd_b_hit), .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [36:0] a, input logic [36:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    // Monitor: every write presented to the register file must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wb_load) begin
            if (sb.size() == 0) chk("unexpected_write", {wb_rd, wb_in}, 37'h0);
            else chk("wb_write", {wb_rd, wb_in}, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] rd, input logic [31:0] d);
        enq_valid = 1'b1;
        enq_rd = rd;
        enq_data = d;
        if (rd != 5'd0) sb.push_back({rd, d});
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_wb_load", 37'(wb_load), 37'd0);
        chk("rst_enq_ready", 37'(enq_ready), 37'd1);
        chk("rst_occupancy", 37'(occupancy), 37'd0);
        chk("rst_wb_rd_in", {wb_rd, wb_in}, 37'd0);
        chk("rst_fwd", {fwd_a_hit, fwd_b_hit, fwd_a_data}, 37'd0);
        #10 rst_n = 1'b1;
        step();
        // Single write: visible on wb_* the cycle after acceptance.
        enq(5'd5, 32'hDEADBEEF);
        chk("t1_wb_load", 37'(wb_load), 37'd1);
        chk("t1_wb", {wb_rd, wb_in}, {5'd5, 32'hDEADBEEF});
        step();
        chk("t1_occ_after", 37'(occupancy), 37'd0);
        // Write-after-write to the same register under stall.
        wb_stall = 1'b1;
        enq(5'd3, 32'h11);
        enq(5'd3, 32'h22);
        rs1 = 5'd3;
        #1;
        chk("t2_fwd_a", {fwd_a_hit, fwd_a_data}, {1'b1, 32'h22});
        chk("t2_occ", 37'(occupancy), 37'd2);
        wb_stall = 1'b0;
        step();
        step();
        chk("t2_occ_drained", 37'(occupancy), 37'd0);
        // Fill to DEPTH under stall, then accept and drain together while full.
        wb_stall = 1'b1;
        enq(5'd1, 32'hA1);
        enq(5'd2, 32'hA2);
        enq(5'd3, 32'hA3);
        enq(5'd4, 32'hA4);
        rs2 = 5'd2;
        #1;
        chk("t3_full_ready", 37'(enq_ready), 37'd0);
        chk("t3_full_occ", 37'(occupancy), 37'd4);
        chk("t3_fwd_b", {fwd_b_hit, fwd_b_data}, {1'b1, 32'hA2});
        wb_stall = 1'b0;
        #1;
        chk("t3_ready_draining", {enq_ready, wb_load}, 37'b11);
        enq(5'd6, 32'h66);
        chk("t3_occ_held", 37'(occupancy), 37'd4);
        repeat (4) step();
        chk("t3_occ_empty", 37'(occupancy), 37'd0);
        // Index zero is accepted and discarded.
        rs1 = 5'd0;
        enq_valid = 1'b1;
        enq_rd = 5'd0;
        enq_data = 32'h55;
        #1;
        chk("t4_ready", 37'(enq_ready), 37'd1);
        step();
        enq_valid = 1'b0;
        chk("t4_occ", 37'(occupancy), 37'd0);
        chk("t4_no_load", 37'(wb_load), 37'd0);
        chk("t4_fwd_miss", {fwd_a_hit, fwd_a_data}, 37'd0);
        // Asynchronous reset with pending entries discards them.
        wb_stall = 1'b1;
        enq(5'd8, 32'h88);
        enq(5'd9, 32'h99);
        enq(5'd10, 32'hAA);
        rs1 = 5'd9;
        #1;
        chk("t5_fwd_pre", {fwd_a_hit, fwd_a_data}, {1'b1, 32'h99});
        wb_stall = 1'b0;
        #1;
        chk("t5_load_pre", 37'(wb_load), 37'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t5_rst_load", 37'(wb_load), 37'd0);
        chk("t5_rst_fwd", {fwd_a_hit, fwd_a_data}, 37'd0);
        chk("t5_rst_occ", 37'(occupancy), 37'd0);
        step();
        #3 rst_n = 1'b1;
        repeat (3) step();
        chk("t5_occ_after", 37'(occupancy), 37'd0);
        // Same-cycle visibility only with the bypass build.
        rs2 = 5'd7;
        enq_valid = 1'b1;
        enq_rd = 5'd7;
        enq_data = 32'h77;
        sb.push_back({5'd7, 32'h77});
        #1;
`ifdef WBQ_ENQ_BYPASS_EN
        chk("t6_byp_same", {fwd_b_hit, fwd_b_data}, {1'b1, 32'h77});
`else
        chk("t6_byp_same", {fwd_b_hit, fwd_b_data}, 37'd0);
`endif
        step();
        enq_valid = 1'b0;
        chk("t6_fwd_next", {fwd_b_hit, fwd_b_data}, {1'b1, 32'h77});
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("sb_empty", 37'(sb.size()), 37'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
